// File: rtl/dump_fsm.sv
// dump_fsm
// Output-side controller for the SHAKE core. It drains squeezed rate blocks
// from the PISO output buffer and streams them downstream as W-bit words on a
// valid/ready handshake. It tracks how many output bits are still owed,
// masks the final partial word, returns each drained buffer to the
// permutation stage and asks for another squeeze when more output is needed.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i                  one-cycle request pulse (length/mode valid with it)
//   output_length_i          requested output length in bits
//   mode_i                   0 = SHAKE128, 1 = SHAKE256
//   output_buffer_valid      PISO holds a freshly squeezed block
//   output_buffer_data       current head word of the PISO
//   output_buffer_consumed   pulse: PISO drained, may be overwritten
//   squeeze_request          pulse: another block is required
//   shift_enable             advance PISO by one word
//   valid_o/data_o/last_o    downstream word stream, last_o marks final word
//   ready_i                  downstream accepts the word
//   busy_o                   high whenever not idle
//   done_o                   pulse when the request completes
module dump_fsm #(
  parameter int W             = 64,
  parameter int LEN_W         = 32,
  parameter int RATE128_WORDS = 21,
  parameter int RATE256_WORDS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] output_length_i,
  input  logic             mode_i,
  input  logic             output_buffer_valid,
  input  logic [W-1:0]     output_buffer_data,
  output logic             output_buffer_consumed,
  output logic             squeeze_request,
  output logic             shift_enable,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = 8;
  localparam int SH_W  = $clog2(W);
  localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLOCK = 2'd1,
    DUMP       = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               mode_q, mode_d;
  // A zero-length request completes without leaving IDLE; this flag delays
  // its done pulse by one cycle so it lines up with the non-zero case timing.
  logic               zero_done_q, zero_done_d;

  logic               is_last;
  logic [W-1:0]       mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      word_cnt_q  <= '0;
      mode_q      <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_cnt_q  <= word_cnt_d;
      mode_q      <= mode_d;
      zero_done_q <= zero_done_d;
    end
  end

  // The final word is the one that covers the last <= W remaining bits.
  // Only the low SH_W bits of the counter matter for the mask because it is
  // applied only when fewer than W bits remain.
  always_comb begin
    is_last = (remaining_q <= W_LEN);
    mask    = '1;
    if (remaining_q < W_LEN) begin
      mask = ~({W{1'b1}} << remaining_q[SH_W-1:0]);
    end
  end

  always_comb begin
    state_d                = state_q;
    remaining_d            = remaining_q;
    word_cnt_d             = word_cnt_q;
    mode_d                 = mode_q;
    zero_done_d            = 1'b0;
    output_buffer_consumed = 1'b0;
    squeeze_request        = 1'b0;
    shift_enable           = 1'b0;
    valid_o                = 1'b0;
    data_o                 = '0;
    last_o                 = 1'b0;
    done_o                 = zero_done_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          remaining_d = output_length_i;
          mode_d      = mode_i;
          if (output_length_i == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = WAIT_BLOCK;
          end
        end
      end

      WAIT_BLOCK: begin
        if (output_buffer_valid) begin
          word_cnt_d = mode_q ? CNT_W'(RATE256_WORDS) : CNT_W'(RATE128_WORDS);
          state_d    = DUMP;
        end
      end

      DUMP: begin
        valid_o = 1'b1;
        data_o  = output_buffer_data & mask;
        last_o  = is_last;
        if (ready_i) begin
          shift_enable = 1'b1;
          remaining_d  = is_last ? '0 : (remaining_q - W_LEN);
          word_cnt_d   = word_cnt_q - CNT_W'(1);
          // Ending the request takes priority over the block boundary so a
          // request that finishes exactly on a boundary does not squeeze.
          if (is_last) begin
            output_buffer_consumed = 1'b1;
            done_o                 = 1'b1;
            state_d                = IDLE;
          end else if (word_cnt_q == CNT_W'(1)) begin
            output_buffer_consumed = 1'b1;
            squeeze_request        = 1'b1;
            state_d                = WAIT_BLOCK;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: doc/dump_fsm.md
Name: dump_fsm

Overview:
- Output-side controller for the SHAKE core; counterpart of the input load path.
- Drains squeezed rate blocks from the PISO output buffer and streams them downstream as W-bit words on a valid/ready handshake.
- Counts the requested output length, masks the final partial word, and hands each drained buffer back to the permutation stage.
- Requests a further squeeze whenever more output is needed.

Parameters:
- W, 64, output word width in bits.
- LEN_W, 32, width of output_length_i and of the internal remaining-bits counter.
- RATE128_WORDS, 21, words per rate block in SHAKE128 (1344/64).
- RATE256_WORDS, 17, words per rate block in SHAKE256 (1088/64).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle pulse from header stage; output_length_i and mode_i are valid with it.
- output_length_i  in  LEN_W  requested output length in bits.
- mode_i  in  1  0 = SHAKE128, 1 = SHAKE256.
- output_buffer_valid  in  1  PISO holds a freshly squeezed block (handshake from permutation stage).
- output_buffer_data  in  W  current head word of the PISO.
- output_buffer_consumed  out  1  one-cycle pulse: PISO drained, may be overwritten.
- squeeze_request  out  1  one-cycle pulse: another block is required.
- shift_enable  out  1  advance PISO by one word.
- valid_o  out  1  data_o holds a valid word.
- data_o  out  W  output word.
- last_o  out  1  current word is the final one of the request.
- ready_i  in  1  downstream accepts the word.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the request completes.

Behaviour:
- Reset:
  - State goes to IDLE; remaining counter, word_cnt and mode register are cleared.
  - All outputs are 0; data_o is 0.
- Register updates: all state changes happen on the clk rising edge.
- IDLE:
  - Outputs busy_o=0 and valid_o=0.
  - On start_i: latch remaining=output_length_i and mode=mode_i.
  - If output_length_i==0: pulse done_o next cycle and stay in IDLE; no squeeze_request is issued.
  - Otherwise go to WAIT_BLOCK.
- start_i while not in IDLE: ignored; the latched values are unchanged.
- WAIT_BLOCK:
  - Outputs valid_o=0.
  - On output_buffer_valid: load word_cnt with RATE128_WORDS or RATE256_WORDS per the latched mode, then go to DUMP.
  - First valid_o is asserted the cycle after output_buffer_valid is sampled.
- DUMP:
  - Outputs valid_o=1; data_o=output_buffer_data, masked.
  - Masking: when remaining<W, bits [W-1:remaining] of data_o are forced to 0.
  - last_o=1 when remaining<=W.
  - Transfer occurs when valid_o&&ready_i. On a transfer:
    - shift_enable=1 in that same cycle.
    - remaining -= min(W, remaining); word_cnt -= 1.
  - Transfer with last_o=1: output_buffer_consumed=1 and done_o=1 in that cycle; next state IDLE.
  - Transfer with last_o=0 and word_cnt==1: output_buffer_consumed=1 and squeeze_request=1 in that cycle; next state WAIT_BLOCK.
  - Otherwise: stay in DUMP.
- Backpressure:
  - With ready_i=0, valid_o stays high and data_o and last_o are stable.
  - No shift_enable and no counter change.
- Final-word priority: when last_o and word_cnt==1 transfer together (request ends exactly on a block boundary), the last_o branch wins and squeeze_request is not asserted.
- Combinational outputs: valid_o, last_o, data_o, shift_enable, output_buffer_consumed, squeeze_request and done_o are derived from the current state and counters in the same cycle.
- Illegal or undefined state encoding goes to IDLE.
- Asynchronous reset during DUMP or WAIT_BLOCK:
  - Immediately drops valid_o and busy_o.
  - No consumed or done pulse is generated.

Test Plan:
- SHAKE128, output_length_i=256, ready_i=1:
  - 4 transfers on 4 consecutive cycles; last_o on the 4th; done_o and output_buffer_consumed on the 4th.
  - squeeze_request never asserted.
- SHAKE128, output_length_i=100:
  - 2 words; the second has data_o[63:36]=0 and data_o[35:0]=PISO[35:0], with last_o=1.
- SHAKE128, output_length_i=2688 (42 words):
  - output_buffer_consumed+squeeze_request pulse on word 21; valid_o=0 in WAIT_BLOCK until output_buffer_valid.
  - output_buffer_consumed+done_o on word 42, with no squeeze_request.
- SHAKE256, output_length_i=1200:
  - squeeze_request after word 17.
  - 19th word has last_o=1 and data_o[63:48]=0.
- Backpressure, SHAKE128, output_length_i=128:
  - ready_i toggles 1,0,0,1; exactly 2 shift_enable pulses; data_o stable while ready_i=0.
- Zero length, then reset:
  - output_length_i=0 gives a done_o pulse with busy_o=0 throughout.
  - rst asserted mid-DUMP: valid_o=0 immediately; a new start_i then behaves as from reset.
